// File: rtl/jtag_axi_pkg.sv
// Shared types for the JTAG-to-AXI bridge: dispatch info/status records and requester-arbiter state.
package jtag_axi_pkg;

  localparam int JTAG_AXI_ARB_MAX_REQ = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        write;
  } s_axi_jtag_info_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] rdata;
  } s_axi_jtag_status_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_st_t;

endpackage

// File: rtl/jtag_axi_rr_pick.sv
// Combinational winner select for the requester arbiter.
// JTAG_AXI_ARB_RR_EN defined: search upward from rr_ptr with wrap; undefined: lowest index wins.
module jtag_axi_rr_pick
  import jtag_axi_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
`ifdef JTAG_AXI_ARB_RR_EN
  input  logic [IW-1:0]    rr_ptr,
`endif
  output logic [N_REQ-1:0] grant_oh,
  output logic [IW-1:0]    grant_idx,
  output logic             grant_any
);

  // Scan candidates in priority order; the first valid one is latched into the outputs.
  always_comb begin
    int            pos;
    logic [IW-1:0] pos_idx;
    logic          hit;
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = 0;
    pos_idx   = '0;
    hit       = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
`ifdef JTAG_AXI_ARB_RR_EN
      pos = int'(rr_ptr) + i;
      pos = (pos >= N_REQ) ? (pos - N_REQ) : pos;
`else
      pos = i;
`endif
      pos_idx            = IW'(pos);
      hit                = req[pos_idx] & ~grant_any;
      grant_oh[pos_idx]  = grant_oh[pos_idx] | hit;
      grant_idx          = hit ? pos_idx : grant_idx;
      grant_any          = grant_any | hit;
    end
  end

endmodule

// File: rtl/jtag_axi_req_arb.sv
// Shares the single JTAG-to-AXI dispatch engine among N_REQ requesters, one transaction at a time.
// Arbitration is round-robin with JTAG_AXI_ARB_RR_EN defined, fixed priority otherwise.
module jtag_axi_req_arb
  import jtag_axi_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WAIT_MAX_CC = 8192
) (
  input  logic               clk,
  input  logic               ares,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  s_axi_jtag_info_t   req_info_i [N_REQ],
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   rsp_valid_o,
  output s_axi_jtag_status_t rsp_status_o,
  output logic               rsp_timeout_o,
  output logic               disp_req_o,
  output s_axi_jtag_info_t   disp_info_o,
  input  logic               disp_ready_i,
  input  logic               disp_done_i,
  input  s_axi_jtag_status_t disp_status_i
);

  localparam int              IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int              WW      = $clog2(WAIT_MAX_CC + 1);
  localparam logic [WW-1:0]   WD_TERM = WW'(WAIT_MAX_CC - 1);
  localparam logic [WW-1:0]   WD_SAT  = {WW{1'b1}};

  arb_st_t            state_r, state_s;
  logic [N_REQ-1:0]   grant_oh_r;
  s_axi_jtag_info_t   info_r;
  logic [WW-1:0]      wd_r;
  logic               wd_term_s;
  logic               disp_req_r;
  logic [N_REQ-1:0]   rsp_valid_r;
  s_axi_jtag_status_t rsp_status_r;
  logic               rsp_timeout_r;
  logic [N_REQ-1:0]   req_ready_s;
  logic [N_REQ-1:0]   pick_oh_s;
  logic [IW-1:0]      pick_idx_s;
  logic               pick_any_s;
`ifdef JTAG_AXI_ARB_RR_EN
  logic [IW-1:0]      grant_r;
  logic [IW-1:0]      rr_ptr_r;
`endif

  jtag_axi_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req       (req_valid_i),
`ifdef JTAG_AXI_ARB_RR_EN
    .rr_ptr    (rr_ptr_r),
`endif
    .grant_oh  (pick_oh_s),
    .grant_idx (pick_idx_s),
    .grant_any (pick_any_s)
  );

  assign wd_term_s = (wd_r >= WD_TERM);

  // Next-state logic; a completion in the terminal-count cycle takes precedence over the abort.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ARB_IDLE:  if (pick_any_s) state_s = ARB_ISSUE; else state_s = ARB_IDLE;
      ARB_ISSUE: if (disp_ready_i) state_s = ARB_WAIT; else state_s = ARB_ISSUE;
      ARB_WAIT:  if (disp_done_i || wd_term_s) state_s = ARB_RESP; else state_s = ARB_WAIT;
      ARB_RESP:  state_s = ARB_IDLE;
      default:   state_s = ARB_IDLE;
    endcase
  end

  // Accept pulse must coincide with the dispatch handshake, so it is decoded from the live ready.
  always_comb begin
    req_ready_s = '0;
    if ((state_r == ARB_ISSUE) && disp_ready_i) req_ready_s = grant_oh_r;
    else req_ready_s = '0;
  end

  // State, grant, watchdog and registered response outputs.
  always_ff @(posedge clk) begin
    if (ares) begin
      state_r       <= ARB_IDLE;
      grant_oh_r    <= '0;
      info_r        <= '0;
      wd_r          <= '0;
      disp_req_r    <= 1'b0;
      rsp_valid_r   <= '0;
      rsp_status_r  <= '0;
      rsp_timeout_r <= 1'b0;
`ifdef JTAG_AXI_ARB_RR_EN
      grant_r       <= '0;
      rr_ptr_r      <= '0;
`endif
    end else begin
      state_r     <= state_s;
      disp_req_r  <= (state_s == ARB_ISSUE);
      rsp_valid_r <= '0;
      case (state_r)
        ARB_IDLE: begin
          if (pick_any_s) begin
            grant_oh_r <= pick_oh_s;
            info_r     <= req_info_i[pick_idx_s];
`ifdef JTAG_AXI_ARB_RR_EN
            grant_r    <= pick_idx_s;
`endif
          end
        end
        ARB_ISSUE: begin
          if (disp_ready_i) wd_r <= '0;
        end
        ARB_WAIT: begin
          if (disp_done_i) begin
            rsp_valid_r   <= grant_oh_r;
            rsp_status_r  <= disp_status_i;
            rsp_timeout_r <= 1'b0;
          end else if (wd_term_s) begin
            rsp_valid_r   <= grant_oh_r;
            rsp_status_r  <= '0;
            rsp_timeout_r <= 1'b1;
          end else if (wd_r != WD_SAT) begin
            wd_r <= wd_r + WW'(1);
          end
        end
        ARB_RESP: begin
`ifdef JTAG_AXI_ARB_RR_EN
          rr_ptr_r <= (grant_r == IW'(N_REQ - 1)) ? '0 : (grant_r + IW'(1));
`endif
        end
        default: begin
          wd_r <= '0;
        end
      endcase
    end
  end

  assign req_ready_o   = req_ready_s;
  assign rsp_valid_o   = rsp_valid_r;
  assign rsp_status_o  = rsp_status_r;
  assign rsp_timeout_o = rsp_timeout_r;
  assign disp_req_o    = disp_req_r;
  assign disp_info_o   = info_r;

endmodule

// File: tb/tb_jtag_axi_req_arb.sv
// Scoreboard bench for jtag_axi_req_arb with the watchdog shortened to 16 cycles.
// The contention vector's expected grant order follows JTAG_AXI_ARB_RR_EN.
module tb_jtag_axi_req_arb;
  import jtag_axi_pkg::*;

  localparam int N    = 4;
  localparam int WMAX = 16;

  typedef struct { logic [N-1:0] oh; int cyc; } acc_t;
  typedef struct { logic [N-1:0] oh; s_axi_jtag_status_t st; logic tmo; int cyc; } rsp_t;

  logic               clk = 1'b0;
  logic               ares = 1'b1;
  logic [N-1:0]       req_valid_i = '0;
  s_axi_jtag_info_t   req_info_i [N];
  logic [N-1:0]       req_ready_o;
  logic [N-1:0]       rsp_valid_o;
  s_axi_jtag_status_t rsp_status_o;
  logic               rsp_timeout_o;
  logic               disp_req_o;
  s_axi_jtag_info_t   disp_info_o;
  logic               disp_ready_i = 1'b0;
  logic               disp_done_i = 1'b0;
  s_axi_jtag_status_t disp_status_i = '0;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  acc_t mon_acc;
  rsp_t mon_rsp;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rsp_seen = 0;
  int   rsp_exp = 0;

`ifdef JTAG_AXI_ARB_RR_EN
  int order [5] = '{0, 1, 2, 3, 0};
`else
  int order [5] = '{0, 0, 0, 0, 0};
`endif

  jtag_axi_req_arb #(.N_REQ(N), .WAIT_MAX_CC(WMAX)) dut (
    .clk           (clk),
    .ares          (ares),
    .req_valid_i   (req_valid_i),
    .req_info_i    (req_info_i),
    .req_ready_o   (req_ready_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_status_o  (rsp_status_o),
    .rsp_timeout_o (rsp_timeout_o),
    .disp_req_o    (disp_req_o),
    .disp_info_o   (disp_info_o),
    .disp_ready_i  (disp_ready_i),
    .disp_done_i   (disp_done_i),
    .disp_status_i (disp_status_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic s_axi_jtag_info_t mk_info(input logic [31:0] a, input logic [31:0] d, input logic w);
    s_axi_jtag_info_t r;
    r.addr  = a;
    r.wdata = d;
    r.wstrb = w ? 4'hF : 4'h0;
    r.write = w;
    return r;
  endfunction

  function automatic s_axi_jtag_status_t mk_st(input logic [1:0] resp, input logic [31:0] rd);
    s_axi_jtag_status_t r;
    r.resp  = resp;
    r.rdata = rd;
    return r;
  endfunction

  // Monitor: every accept / completion pulse is popped against the scoreboard.
  always @(negedge clk) begin
    if (req_ready_o !== '0 && rsp_valid_o !== '0)
      check("overlap", {req_ready_o, rsp_valid_o}, 128'd0);
    if (req_ready_o !== '0) begin
      if (acc_q.size() == 0) check("acc_unexpected", req_ready_o, 128'd0);
      else begin
        mon_acc = acc_q.pop_front();
        check("acc_onehot", req_ready_o, mon_acc.oh);
        check("acc_cycle", cyc, mon_acc.cyc);
      end
    end
    if (rsp_valid_o !== '0) begin
      rsp_seen++;
      if (rsp_q.size() == 0) check("rsp_unexpected", rsp_valid_o, 128'd0);
      else begin
        mon_rsp = rsp_q.pop_front();
        check("rsp_onehot", rsp_valid_o, mon_rsp.oh);
        check("rsp_status", rsp_status_o, mon_rsp.st);
        check("rsp_timeout", rsp_timeout_o, mon_rsp.tmo);
        check("rsp_cycle", cyc, mon_rsp.cyc);
      end
    end
  end

  // One grant: wait for the dispatch request, hold off ready, accept, then complete or time out.
  task automatic serve(input int idx, input s_axi_jtag_info_t info, input int ready_delay,
                       input int done_delay, input s_axi_jtag_status_t st, input bit drop);
    int n;
    int acc;
    bit hold_ok;
    logic [N-1:0] oh;
    n  = 0;
    oh = '0;
    oh[idx] = 1'b1;
    while (disp_req_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("disp_req_wait", n < 200, 1'b1);
    if (n >= 200) return;
    check("disp_info", disp_info_o, info);
    hold_ok = 1'b1;
    for (int i = 0; i < ready_delay; i++) begin
      step();
      @(negedge clk);
      if (disp_req_o !== 1'b1 || req_ready_o !== '0 || disp_info_o !== info) hold_ok = 1'b0;
    end
    if (ready_delay > 0) check("issue_hold", hold_ok, 1'b1);
    step();
    disp_ready_i = 1'b1;
    acc = cyc;
    acc_q.push_back('{oh, acc});
    step();
    disp_ready_i = 1'b0;
    if (drop) req_valid_i[idx] = 1'b0;
    rsp_exp++;
    if (done_delay > 0) begin
      repeat (done_delay - 1) step();
      disp_done_i   = 1'b1;
      disp_status_i = st;
      rsp_q.push_back('{oh, st, 1'b0, cyc + 1});
      step();
      disp_done_i = 1'b0;
    end else begin
      rsp_q.push_back('{oh, 34'd0, 1'b1, acc + WMAX + 1});
      repeat (WMAX) step();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) req_info_i[i] = '0;
    ares = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst_disp_req", disp_req_o, 1'b0);
    check("rst_req_ready", req_ready_o, 4'd0);
    check("rst_rsp_valid", rsp_valid_o, 4'd0);
    check("rst_rsp_status", rsp_status_o, 34'd0);
    check("rst_rsp_timeout", rsp_timeout_o, 1'b0);
    check("rst_disp_info", disp_info_o, 69'd0);
    step();
    ares = 1'b0;
    step();

    // Contention: all requesters held valid for five grants.
    for (int i = 0; i < N; i++) req_info_i[i] = mk_info(32'h2000_0000 + 32'(i * 16), 32'h0, 1'b0);
    req_valid_i = 4'b1111;
    for (int k = 0; k < 5; k++)
      serve(order[k], req_info_i[order[k]], 0, 2, mk_st(2'b00, 32'h0000_0100 + 32'(k)), 1'b0);
    req_valid_i = '0;
    repeat (3) step();

    // Single request with latency check.
    req_info_i[2] = mk_info(32'h1000_0000, 32'h0, 1'b0);
    req_valid_i = 4'b0100;
    @(negedge clk);
    check("t1_lat_idle", disp_req_o, 1'b0);
    step();
    @(negedge clk);
    check("t1_lat_issue", disp_req_o, 1'b1);
    serve(2, req_info_i[2], 3, 10, mk_st(2'b00, 32'hCAFE_0001), 1'b1);
    repeat (2) step();

    // Watchdog timeout, then a late completion that must be dropped.
    req_info_i[1] = mk_info(32'h3000_0040, 32'h5555_AAAA, 1'b1);
    req_valid_i = 4'b0010;
    serve(1, req_info_i[1], 0, 0, 34'd0, 1'b1);
    repeat (2) step();
    disp_done_i   = 1'b1;
    disp_status_i = mk_st(2'b10, 32'hDEAD_BEEF);
    step();
    disp_done_i = 1'b0;
    repeat (3) step();
    check("t3_late_done", rsp_seen, rsp_exp);

    // Done exactly at the terminal count.
    req_info_i[3] = mk_info(32'h4000_0000, 32'h0, 1'b0);
    req_valid_i = 4'b1000;
    serve(3, req_info_i[3], 1, WMAX, mk_st(2'b10, 32'h1234_5678), 1'b1);
    repeat (2) step();

    // Backpressure: ready withheld for 50 cycles.
    req_info_i[1] = mk_info(32'hA5A5_0000, 32'h0F0F_0F0F, 1'b1);
    req_valid_i = 4'b0010;
    serve(1, req_info_i[1], 50, 4, mk_st(2'b00, 32'h0000_0000), 1'b1);
    repeat (2) step();

    // Reset while waiting for completion.
    req_info_i[2] = mk_info(32'h5000_0000, 32'h0, 1'b0);
    req_valid_i = 4'b0100;
    begin
      int n;
      n = 0;
      while (disp_req_o !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("t5_disp_req_wait", n < 200, 1'b1);
    end
    step();
    disp_ready_i = 1'b1;
    acc_q.push_back('{4'b0100, cyc});
    step();
    disp_ready_i = 1'b0;
    req_valid_i  = '0;
    repeat (3) step();
    ares = 1'b1;
    step();
    ares = 1'b0;
    @(negedge clk);
    check("t5_disp_req", disp_req_o, 1'b0);
    check("t5_req_ready", req_ready_o, 4'd0);
    check("t5_rsp_valid", rsp_valid_o, 4'd0);
    check("t5_rsp_status", rsp_status_o, 34'd0);
    check("t5_rsp_timeout", rsp_timeout_o, 1'b0);
    check("t5_disp_info", disp_info_o, 69'd0);
    step();
    disp_done_i   = 1'b1;
    disp_status_i = mk_st(2'b11, 32'h0BAD_0BAD);
    step();
    disp_done_i = 1'b0;
    repeat (4) step();
    check("t5_no_rsp", rsp_seen, rsp_exp);
    req_info_i[0] = mk_info(32'h6000_0008, 32'h0, 1'b0);
    req_valid_i = 4'b0001;
    serve(0, req_info_i[0], 1, 5, mk_st(2'b00, 32'h7777_0000), 1'b1);
    repeat (3) step();

    check("acc_q_empty", acc_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);
    check("rsp_count", rsp_seen, rsp_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "time limit reached");
  end

endmodule
